fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC and selects the next PC from PC+4, the branch target, the j/jal target, or the jr target (JumpReg/nPCin from the jump unit). It drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register. Control transfers resolve in D with one architectural delay slot, so a redirect never squashes the instruction already fetched.

---
 rtl/fetch_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, next-PC select, IF/ID register; fetched word reaches InstrD one edge after PCF.
// StallF holds the PC (dropping that cycle's redirect), StallD holds IF/ID and overrides FlushD.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchD,
  input  logic [31:0] BranchTarget,
  input  logic        JumpD,
  input  logic [31:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] nPCin,
  output logic [31:0] ImAddr,
  input  logic [31:0] ImData,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        AdELD
);

  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS);

  logic [31:0] pcPlus4F;
  logic [31:0] nextPC;
  logic        fetchFault;
  logic [31:0] fetchWord;

  assign ImAddr   = PCF;
  assign pcPlus4F = PCF + 32'd4;

  // jr outranks j/jal, which outranks a taken branch.
  always_comb begin
    nextPC = pcPlus4F;
    if (JumpReg)
      nextPC = nPCin;
    else if (JumpD)
      nextPC = JumpTarget;
    else if (BranchD)
      nextPC = BranchTarget;
  end

  assign fetchFault = (PCF[1:0] != 2'b00) || (PCF < PC_RESET) || (PCF >= PC_LIMIT);
  assign fetchWord  = fetchFault ? 32'd0 : ImData;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      PCF <= PC_RESET;
    else if (!StallF)
      PCF <= nextPC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= 32'd0;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
      AdELD    <= 1'b0;
    end else if (!StallD) begin
      if (FlushD) begin
        InstrD   <= 32'd0;
        PCD      <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
        AdELD    <= 1'b0;
      end else begin
        InstrD   <= fetchWord;
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
        AdELD    <= fetchFault;
      end
    end
  end

endmodule
